// File: rtl/gci_irq_arbiter.sv
// Purpose : shares the master IRQ channel among four GCI nodes. The highest priority wins; ties go round-robin.
// Latency : an eligible request seen in IDLE raises oMASTER_IRQ_REQ one cycle later. The node ACK pulse follows master ACK by one cycle.
// Backpress: iMASTER_IRQ_BUSY blocks new arbitration and holds a pending REQ. It also marks every node busy.
//
// Ports:
//   iCLOCK, iRESET                 clock, asynchronous active-high reset
//   iNODE_INFO_VALID[3:0]          per-node init complete (invalid nodes never win)
//   iNODE_IRQ_REQ[3:0]             per-node level IRQ request
//   iNODE_PRIORITY0..3[7:0]        per-node priority, larger wins
//   oNODE_IRQ_ACK[3:0]             one-hot acknowledge pulse to the granted node
//   oNODE_IRQ_BUSY[3:0]            per-node busy, blocks new IRQ capture in the node
//   oMASTER_IRQ_REQ/NUM/PRIORITY   request presented to the master
//   iMASTER_IRQ_ACK/BUSY/DONE      master accept, master busy, service-complete pulse
//   oTIMEOUT_ERR                   sticky SERVICE-timeout flag
module gci_irq_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLE = 16'hFFFF,
  parameter logic [1:0]  DEFAULT_LAST  = 2'h3
) (
  input  logic       iCLOCK,
  input  logic       iRESET,
  input  logic [3:0] iNODE_INFO_VALID,
  input  logic [3:0] iNODE_IRQ_REQ,
  input  logic [7:0] iNODE_PRIORITY0,
  input  logic [7:0] iNODE_PRIORITY1,
  input  logic [7:0] iNODE_PRIORITY2,
  input  logic [7:0] iNODE_PRIORITY3,
  output logic [3:0] oNODE_IRQ_ACK,
  output logic [3:0] oNODE_IRQ_BUSY,
  output logic       oMASTER_IRQ_REQ,
  output logic [1:0] oMASTER_IRQ_NUM,
  output logic [7:0] oMASTER_IRQ_PRIORITY,
  input  logic       iMASTER_IRQ_ACK,
  input  logic       iMASTER_IRQ_BUSY,
  input  logic       iMASTER_IRQ_DONE,
  output logic       oTIMEOUT_ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE, ST_HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  prio_q, prio_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  ack_q, ack_d;
  logic        terr_q, terr_d;

  logic [7:0]  pri [4];
  logic [3:0]  eligible;
  logic [7:0]  max_pri;
  logic [1:0]  scan_idx;
  logic [1:0]  win_idx;
  logic        win_found;

  assign pri[0]   = iNODE_PRIORITY0;
  assign pri[1]   = iNODE_PRIORITY1;
  assign pri[2]   = iNODE_PRIORITY2;
  assign pri[3]   = iNODE_PRIORITY3;
  assign eligible = iNODE_INFO_VALID & iNODE_IRQ_REQ;

  // Winner: the highest priority among eligible nodes. Ties are broken by scanning
  // from the node after the last one serviced.
  always_comb begin
    max_pri   = '0;
    scan_idx  = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (eligible[i] && (pri[i] > max_pri)) max_pri = pri[i];
    end
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + k[1:0];
      if (!win_found && eligible[scan_idx] && (pri[scan_idx] == max_pri)) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    terr_d  = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (!iMASTER_IRQ_BUSY && win_found) begin
          grant_d = win_idx;
          prio_d  = pri[win_idx];
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // ACK wins over a simultaneous withdrawal. Master busy simply holds this state.
        if (iMASTER_IRQ_ACK) begin
          ack_d[grant_q] = 1'b1;
          cnt_d          = '0;
          state_d        = ST_SERVICE;
        end else if (!eligible[grant_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (iMASTER_IRQ_DONE) begin
          last_d  = grant_q;
          state_d = ST_HOLD;
        end else if (cnt_q == TIMEOUT_CYCLE) begin
          terr_d  = 1'b1;
          last_d  = grant_q;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // One spare cycle lets the serviced node drop its level request.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= DEFAULT_LAST;
      prio_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    oNODE_IRQ_BUSY = '0;
    for (int i = 0; i < 4; i++) begin
      oNODE_IRQ_BUSY[i] = iMASTER_IRQ_BUSY | ((state_q != ST_IDLE) && (grant_q != 2'(i)));
    end
  end

  assign oMASTER_IRQ_REQ      = (state_q == ST_REQ);
  assign oMASTER_IRQ_NUM      = grant_q;
  assign oMASTER_IRQ_PRIORITY = prio_q;
  assign oNODE_IRQ_ACK        = ack_q;
  assign oTIMEOUT_ERR         = terr_q;

endmodule

// File: tb/tb_gci_irq_arbiter.sv
// Directed bench for gci_irq_arbiter. It uses a short timeout (8) so the abort path is reachable.
module tb_gci_irq_arbiter;
  logic       iCLOCK = 1'b0;
  logic       iRESET;
  logic [3:0] iNODE_INFO_VALID;
  logic [3:0] iNODE_IRQ_REQ;
  logic [7:0] iNODE_PRIORITY0, iNODE_PRIORITY1, iNODE_PRIORITY2, iNODE_PRIORITY3;
  logic [3:0] oNODE_IRQ_ACK;
  logic [3:0] oNODE_IRQ_BUSY;
  logic       oMASTER_IRQ_REQ;
  logic [1:0] oMASTER_IRQ_NUM;
  logic [7:0] oMASTER_IRQ_PRIORITY;
  logic       iMASTER_IRQ_ACK, iMASTER_IRQ_BUSY, iMASTER_IRQ_DONE;
  logic       oTIMEOUT_ERR;

  int pass_cnt  = 0;
  int total_cnt = 0;

  gci_irq_arbiter #(.TIMEOUT_CYCLE(16'h0008), .DEFAULT_LAST(2'h3)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .iNODE_INFO_VALID(iNODE_INFO_VALID), .iNODE_IRQ_REQ(iNODE_IRQ_REQ),
    .iNODE_PRIORITY0(iNODE_PRIORITY0), .iNODE_PRIORITY1(iNODE_PRIORITY1),
    .iNODE_PRIORITY2(iNODE_PRIORITY2), .iNODE_PRIORITY3(iNODE_PRIORITY3),
    .oNODE_IRQ_ACK(oNODE_IRQ_ACK), .oNODE_IRQ_BUSY(oNODE_IRQ_BUSY),
    .oMASTER_IRQ_REQ(oMASTER_IRQ_REQ), .oMASTER_IRQ_NUM(oMASTER_IRQ_NUM),
    .oMASTER_IRQ_PRIORITY(oMASTER_IRQ_PRIORITY),
    .iMASTER_IRQ_ACK(iMASTER_IRQ_ACK), .iMASTER_IRQ_BUSY(iMASTER_IRQ_BUSY),
    .iMASTER_IRQ_DONE(iMASTER_IRQ_DONE), .oTIMEOUT_ERR(oTIMEOUT_ERR)
  );

  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic clear_nodes();
    iNODE_INFO_VALID = '0;
    iNODE_IRQ_REQ    = '0;
    iNODE_PRIORITY0  = '0;
    iNODE_PRIORITY1  = '0;
    iNODE_PRIORITY2  = '0;
    iNODE_PRIORITY3  = '0;
  endtask

  task automatic set_node(input int n, input logic v, input logic r, input logic [7:0] p);
    iNODE_INFO_VALID[n] = v;
    iNODE_IRQ_REQ[n]    = r;
    case (n)
      0: iNODE_PRIORITY0 = p;
      1: iNODE_PRIORITY1 = p;
      2: iNODE_PRIORITY2 = p;
      default: iNODE_PRIORITY3 = p;
    endcase
  endtask

  // Entered right after the edge into REQ. It returns right after the edge into IDLE.
  task automatic serve(input int n, input bit drop);
    iMASTER_IRQ_ACK = 1'b1;
    tick();
    iMASTER_IRQ_ACK  = 1'b0;
    iMASTER_IRQ_DONE = 1'b1;
    tick();
    iMASTER_IRQ_DONE = 1'b0;
    if (drop) iNODE_IRQ_REQ[n] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    iRESET = 1'b1;
    set_node(1, 1'b1, 1'b1, 8'h07);
    iMASTER_IRQ_ACK = 1'b1;
    tick(); tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL rst_req got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_NUM !== 2'd0) $display("FAIL rst_num got=%0d exp=0", oMASTER_IRQ_NUM); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_PRIORITY !== 8'h00) $display("FAIL rst_pri got=%h exp=00", oMASTER_IRQ_PRIORITY); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b0000) $display("FAIL rst_ack got=%b exp=0000", oNODE_IRQ_ACK); else pass_cnt++;
    total_cnt++; if (oTIMEOUT_ERR !== 1'b0) $display("FAIL rst_terr got=%b exp=0", oTIMEOUT_ERR); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b0000) $display("FAIL rst_busy got=%b exp=0000", oNODE_IRQ_BUSY); else pass_cnt++;
    iMASTER_IRQ_BUSY = 1'b1;
    #1;
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b1111) $display("FAIL rst_busy_follow got=%b exp=1111", oNODE_IRQ_BUSY); else pass_cnt++;
    iMASTER_IRQ_BUSY = 1'b0;
    iMASTER_IRQ_ACK  = 1'b0;
    clear_nodes();
    iRESET = 1'b0;
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL rst_idle_req got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
  endtask

  task automatic test_single();
    set_node(2, 1'b1, 1'b1, 8'h10);
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b1) $display("FAIL single_req got=%b exp=1", oMASTER_IRQ_REQ); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_NUM !== 2'd2) $display("FAIL single_num got=%0d exp=2", oMASTER_IRQ_NUM); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_PRIORITY !== 8'h10) $display("FAIL single_pri got=%h exp=10", oMASTER_IRQ_PRIORITY); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b1011) $display("FAIL single_busy got=%b exp=1011", oNODE_IRQ_BUSY); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b0000) $display("FAIL single_noack got=%b exp=0000", oNODE_IRQ_ACK); else pass_cnt++;
    iMASTER_IRQ_ACK = 1'b1;
    tick();
    iMASTER_IRQ_ACK = 1'b0;
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b0100) $display("FAIL single_ack got=%b exp=0100", oNODE_IRQ_ACK); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL single_svc_req got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    tick();
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b0000) $display("FAIL single_ack_1cyc got=%b exp=0000", oNODE_IRQ_ACK); else pass_cnt++;
    iMASTER_IRQ_DONE = 1'b1;
    tick();
    iMASTER_IRQ_DONE = 1'b0;
    iNODE_IRQ_REQ[2] = 1'b0;
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b1011) $display("FAIL single_hold_busy got=%b exp=1011", oNODE_IRQ_BUSY); else pass_cnt++;
    tick();
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b0000) $display("FAIL single_idle_busy got=%b exp=0000", oNODE_IRQ_BUSY); else pass_cnt++;
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL single_rearb got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    clear_nodes();
  endtask

  task automatic test_priority();
    set_node(0, 1'b1, 1'b1, 8'h05);
    set_node(1, 1'b1, 1'b1, 8'h20);
    set_node(3, 1'b1, 1'b1, 8'h1F);
    tick();
    total_cnt++; if (oMASTER_IRQ_NUM !== 2'd1) $display("FAIL prio_first got=%0d exp=1", oMASTER_IRQ_NUM); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_PRIORITY !== 8'h20) $display("FAIL prio_first_pri got=%h exp=20", oMASTER_IRQ_PRIORITY); else pass_cnt++;
    serve(1, 1'b1);
    tick();
    total_cnt++; if (oMASTER_IRQ_NUM !== 2'd3) $display("FAIL prio_second got=%0d exp=3", oMASTER_IRQ_NUM); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_PRIORITY !== 8'h1F) $display("FAIL prio_second_pri got=%h exp=1f", oMASTER_IRQ_PRIORITY); else pass_cnt++;
    serve(3, 1'b1);
    tick();
    total_cnt++; if (oMASTER_IRQ_NUM !== 2'd0) $display("FAIL prio_third got=%0d exp=0", oMASTER_IRQ_NUM); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b1) $display("FAIL prio_third_req got=%b exp=1", oMASTER_IRQ_REQ); else pass_cnt++;
    serve(0, 1'b1);
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL prio_drained got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    clear_nodes();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_num;
    iRESET = 1'b1;
    #2;
    iRESET = 1'b0;
    for (int n = 0; n < 4; n++) set_node(n, 1'b1, 1'b1, 8'h40);
    for (int k = 0; k < 5; k++) begin
      exp_num = 2'(k % 4);
      tick();
      total_cnt++; if (oMASTER_IRQ_NUM !== exp_num || oMASTER_IRQ_REQ !== 1'b1) $display("FAIL rr_grant%0d got=%0d/req=%b exp=%0d/req=1", k, oMASTER_IRQ_NUM, oMASTER_IRQ_REQ, exp_num); else pass_cnt++;
      serve(k % 4, 1'b0);
    end
    clear_nodes();
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL rr_drained got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
  endtask

  task automatic test_withdraw();
    set_node(1, 1'b1, 1'b1, 8'h30);
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b1 || oMASTER_IRQ_NUM !== 2'd1) $display("FAIL wd_req got=%b/%0d exp=1/1", oMASTER_IRQ_REQ, oMASTER_IRQ_NUM); else pass_cnt++;
    iNODE_IRQ_REQ[1] = 1'b0;
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL wd_idle got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b0000) $display("FAIL wd_noack got=%b exp=0000", oNODE_IRQ_ACK); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b0000) $display("FAIL wd_busy got=%b exp=0000", oNODE_IRQ_BUSY); else pass_cnt++;
    tick();
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b0000) $display("FAIL wd_noack2 got=%b exp=0000", oNODE_IRQ_ACK); else pass_cnt++;
    set_node(0, 1'b0, 1'b1, 8'hFF);
    set_node(2, 1'b1, 1'b1, 8'h01);
    tick();
    total_cnt++; if (oMASTER_IRQ_NUM !== 2'd2) $display("FAIL inv_skip got=%0d exp=2", oMASTER_IRQ_NUM); else pass_cnt++;
    serve(2, 1'b1);
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL inv_never got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL inv_never2 got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    clear_nodes();
    set_node(3, 1'b1, 1'b1, 8'h33);
    tick();
    total_cnt++; if (oMASTER_IRQ_NUM !== 2'd3) $display("FAIL prec_num got=%0d exp=3", oMASTER_IRQ_NUM); else pass_cnt++;
    iNODE_IRQ_REQ[3] = 1'b0;
    iMASTER_IRQ_ACK  = 1'b1;
    tick();
    iMASTER_IRQ_ACK = 1'b0;
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b1000) $display("FAIL prec_ack got=%b exp=1000", oNODE_IRQ_ACK); else pass_cnt++;
    iMASTER_IRQ_DONE = 1'b1;
    tick();
    iMASTER_IRQ_DONE = 1'b0;
    tick();
    clear_nodes();
  endtask

  task automatic test_timeout();
    set_node(1, 1'b1, 1'b1, 8'h11);
    tick();
    iMASTER_IRQ_ACK = 1'b1;
    tick();
    iMASTER_IRQ_ACK  = 1'b0;
    iNODE_IRQ_REQ[1] = 1'b0;
    repeat (8) tick();
    total_cnt++; if (oTIMEOUT_ERR !== 1'b0) $display("FAIL to_early got=%b exp=0", oTIMEOUT_ERR); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b1101) $display("FAIL to_svc_busy got=%b exp=1101", oNODE_IRQ_BUSY); else pass_cnt++;
    tick();
    total_cnt++; if (oTIMEOUT_ERR !== 1'b1) $display("FAIL to_set got=%b exp=1", oTIMEOUT_ERR); else pass_cnt++;
    tick();
    set_node(2, 1'b1, 1'b1, 8'h22);
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b1 || oMASTER_IRQ_NUM !== 2'd2) $display("FAIL to_resume got=%b/%0d exp=1/2", oMASTER_IRQ_REQ, oMASTER_IRQ_NUM); else pass_cnt++;
    total_cnt++; if (oTIMEOUT_ERR !== 1'b1) $display("FAIL to_sticky got=%b exp=1", oTIMEOUT_ERR); else pass_cnt++;
    serve(2, 1'b1);
    clear_nodes();
  endtask

  task automatic test_busy_reset();
    iMASTER_IRQ_BUSY = 1'b1;
    set_node(3, 1'b1, 1'b1, 8'h50);
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL busy_idle got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b1111) $display("FAIL busy_all got=%b exp=1111", oNODE_IRQ_BUSY); else pass_cnt++;
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL busy_idle2 got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
    iMASTER_IRQ_BUSY = 1'b0;
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b1 || oMASTER_IRQ_PRIORITY !== 8'h50) $display("FAIL busy_release got=%b/%h exp=1/50", oMASTER_IRQ_REQ, oMASTER_IRQ_PRIORITY); else pass_cnt++;
    iMASTER_IRQ_BUSY = 1'b1;
    tick();
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b1 || oNODE_IRQ_BUSY !== 4'b1111) $display("FAIL busy_hold got=%b/%b exp=1/1111", oMASTER_IRQ_REQ, oNODE_IRQ_BUSY); else pass_cnt++;
    iMASTER_IRQ_BUSY = 1'b0;
    iMASTER_IRQ_ACK  = 1'b1;
    tick();
    iMASTER_IRQ_ACK = 1'b0;
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b1000) $display("FAIL busy_ack got=%b exp=1000", oNODE_IRQ_ACK); else pass_cnt++;
    #2;
    iRESET = 1'b1;
    #1;
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b0000) $display("FAIL arst_ack got=%b exp=0000", oNODE_IRQ_ACK); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_NUM !== 2'd0 || oMASTER_IRQ_PRIORITY !== 8'h00) $display("FAIL arst_numpri got=%0d/%h exp=0/00", oMASTER_IRQ_NUM, oMASTER_IRQ_PRIORITY); else pass_cnt++;
    total_cnt++; if (oTIMEOUT_ERR !== 1'b0) $display("FAIL arst_terr got=%b exp=0", oTIMEOUT_ERR); else pass_cnt++;
    total_cnt++; if (oNODE_IRQ_BUSY !== 4'b0000 || oMASTER_IRQ_REQ !== 1'b0) $display("FAIL arst_idle got=%b/%b exp=0000/0", oNODE_IRQ_BUSY, oMASTER_IRQ_REQ); else pass_cnt++;
    clear_nodes();
    tick();
    iRESET = 1'b0;
    iMASTER_IRQ_ACK = 1'b1;
    tick();
    iMASTER_IRQ_ACK = 1'b0;
    total_cnt++; if (oNODE_IRQ_ACK !== 4'b0000) $display("FAIL stray_ack got=%b exp=0000", oNODE_IRQ_ACK); else pass_cnt++;
    total_cnt++; if (oMASTER_IRQ_REQ !== 1'b0) $display("FAIL post_rst_req got=%b exp=0", oMASTER_IRQ_REQ); else pass_cnt++;
  endtask

  initial begin
    iRESET           = 1'b1;
    iMASTER_IRQ_ACK  = 1'b0;
    iMASTER_IRQ_BUSY = 1'b0;
    iMASTER_IRQ_DONE = 1'b0;
    clear_nodes();
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_withdraw();
    test_timeout();
    test_busy_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
